// File: rtl/hob_ram_if.sv
// Port bundle for hob_ram: one write port, one registered-address read port, plus clear status.
// Handshake: a write is taken at a rising edge where wren=1 and busy=0; while busy=1 the
// RAM is not ready and any asserted wren is dropped, not queued. Reads are never stalled.
interface hob_ram_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 6
) ();
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] wraddress;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic [DATA_WIDTH-1:0] q;
    logic                  busy;

    modport master (
        output data,
        output wraddress,
        output wren,
        output rdaddress,
        input  q,
        input  busy
    );

    modport slave (
        input  data,
        input  wraddress,
        input  wren,
        input  rdaddress,
        output q,
        output busy
    );
endinterface

// File: rtl/hob_ram.sv
// Simple dual-port synchronous RAM for perceptron high-order-bit weight rows, with a
// self-timed clear sweep that writes INIT_VALUE to every entry after reset.
module hob_ram #(
    parameter int                    DATA_WIDTH = 36,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    hob_ram_if.slave              bus,
    output logic                  dbg_state,
    output logic [ADDR_WIDTH-1:0] dbg_clr_addr
);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [ADDR_WIDTH-1:0] clr_addr_d;
    logic                  clr_we;

    logic                  user_we;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  collide_r;
    logic [DATA_WIDTH-1:0] old_word_r;

    // Clear sequencer: reset parks it at address 0; it only advances once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign bus.busy     = (state_q == ST_CLEAR);
    assign dbg_state    = state_q;
    assign dbg_clr_addr = clr_addr_q;

    // Single physical write port shared by the sweep and the user; the sweep owns it while busy.
    always_comb begin
        user_we   = bus.wren && (state_q == ST_IDLE) && !reset;
        mem_we    = (clr_we && !reset) || user_we;
        mem_addr  = bus.wraddress;
        mem_wdata = bus.data;
        if (clr_we) begin
            mem_addr  = clr_addr_q;
            mem_wdata = INIT_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Read address is captured every edge. When a user write hits the address being
    // sampled, the pre-write word is held aside so q still shows the old contents.
    always_ff @(posedge clk) begin
        rd_addr_r  <= bus.rdaddress;
        collide_r  <= user_we && (bus.wraddress == bus.rdaddress);
        old_word_r <= mem[bus.rdaddress];
    end

    always_comb begin
        if (state_q == ST_CLEAR) begin
            bus.q = INIT_VALUE;
        end else if (collide_r) begin
            bus.q = old_word_r;
        end else begin
            bus.q = mem[rd_addr_r];
        end
    end
endmodule

// File: tb/tb_hob_ram.sv
// Directed bench for hob_ram: default 64x36 instance plus a 256x32 re-parameterized instance.
module tb_hob_ram;
    logic clk;
    logic reset;
    logic reset2;
    logic       dbg_state;
    logic [5:0] dbg_clr_addr;
    logic       dbg_state2;
    logic [7:0] dbg_clr_addr2;

    int checks = 0;
    int passes = 0;

    hob_ram_if #(.DATA_WIDTH(36), .ADDR_WIDTH(6)) bus  ();
    hob_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

    hob_ram #(.DATA_WIDTH(36), .ADDR_WIDTH(6), .INIT_VALUE(36'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dbg_state    (dbg_state),
        .dbg_clr_addr (dbg_clr_addr)
    );

    hob_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .INIT_VALUE(32'h0)) dut2 (
        .clk          (clk),
        .reset        (reset2),
        .bus          (bus2),
        .dbg_state    (dbg_state2),
        .dbg_clr_addr (dbg_clr_addr2)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [35:0] wdata);
        bus.wraddress = addr;
        bus.data      = wdata;
        bus.wren      = 1'b1;
        tick();
        bus.wren      = 1'b0;
        bus.data      = 'x;
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        bus.wren = 1'b0;
        bus.rdaddress = 6'd0;
        tick();
        checks++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", bus.busy); else passes++;
        checks++; if (dbg_state !== 1'b1) $display("FAIL reset_state: got %b expected 1", dbg_state); else passes++;
        checks++; if (bus.q !== 36'h0) $display("FAIL reset_q: got %h expected 0", bus.q); else passes++;
        tick();
        tick();
        checks++; if (dbg_clr_addr !== 6'd0) $display("FAIL reset_hold_addr: got %0d expected 0", dbg_clr_addr); else passes++;
        reset = 1'b0;
        bus.wren = 1'b1;
        bus.data = 36'hFFFFFFFFF;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            bus.wraddress = 6'(i);
            tick();
            if (!bus.busy) break;
            cnt++;
        end
        bus.wren = 1'b0;
        bus.data = 'x;
        checks++; if (cnt !== 64) $display("FAIL reset_busy_len: got %0d expected 64", cnt); else passes++;
        checks++; if (dbg_state !== 1'b0) $display("FAIL reset_idle: got %b expected 0", dbg_state); else passes++;
        for (int i = 0; i < 64; i++) begin
            bus.rdaddress = 6'(i);
            tick();
            checks++; if (bus.q !== 36'h0) $display("FAIL reset_clear_a%0d: got %h expected 0", i, bus.q); else passes++;
        end
    endtask

    task automatic test_latency();
        do_write(6'd5, 36'h123456789);
        bus.rdaddress = 6'd5;
        tick();
        checks++; if (bus.q !== 36'h123456789) $display("FAIL lat_a5: got %h expected 123456789", bus.q); else passes++;
        bus.rdaddress = 6'd6;
        tick();
        checks++; if (bus.q !== 36'h0) $display("FAIL lat_a6: got %h expected 0", bus.q); else passes++;
        bus.wraddress = 6'd5;
        bus.data = 'x;
        bus.wren = 1'b0;
        tick();
        tick();
        tick();
        bus.rdaddress = 6'd5;
        tick();
        checks++; if (bus.q !== 36'h123456789) $display("FAIL x_data_a5: got %h expected 123456789", bus.q); else passes++;
    endtask

    task automatic test_read_during_write();
        do_write(6'd9, 36'hA);
        bus.wraddress = 6'd9;
        bus.data = 36'hB;
        bus.wren = 1'b1;
        bus.rdaddress = 6'd9;
        tick();
        bus.wren = 1'b0;
        checks++; if (bus.q !== 36'hA) $display("FAIL rdw_old: got %h expected a", bus.q); else passes++;
        tick();
        checks++; if (bus.q !== 36'hB) $display("FAIL rdw_new: got %h expected b", bus.q); else passes++;
        bus.wraddress = 6'd10;
        bus.data = 36'hC;
        bus.wren = 1'b1;
        bus.rdaddress = 6'd5;
        tick();
        bus.wren = 1'b0;
        checks++; if (bus.q !== 36'h123456789) $display("FAIL indep_rd: got %h expected 123456789", bus.q); else passes++;
        bus.rdaddress = 6'd10;
        tick();
        checks++; if (bus.q !== 36'hC) $display("FAIL indep_wr: got %h expected c", bus.q); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        for (int i = 0; i < 64; i++) begin
            bus.wraddress = 6'(i);
            bus.data = 36'(i * 3 + 1);
            bus.wren = 1'b1;
            tick();
        end
        bus.wren = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            bus.rdaddress = 6'(i);
            exp = 36'(i * 3 + 1);
            tick();
            checks++; if (bus.q !== exp) $display("FAIL sweep_a%0d: got %h expected %h", i, bus.q, exp); else passes++;
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rdaddress = 6'd5;
        for (int i = 0; i < 30; i++) tick();
        checks++; if (dbg_clr_addr !== 6'd30) $display("FAIL mid_clr_addr: got %0d expected 30", dbg_clr_addr); else passes++;
        checks++; if (bus.q !== 36'h0) $display("FAIL mid_busy_q: got %h expected 0", bus.q); else passes++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (dbg_clr_addr !== 6'd0) $display("FAIL mid_restart: got %0d expected 0", dbg_clr_addr); else passes++;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bus.busy) break;
            cnt++;
        end
        checks++; if (cnt !== 64) $display("FAIL mid_busy_len: got %0d expected 64", cnt); else passes++;
        bus.rdaddress = 6'd50;
        tick();
        checks++; if (bus.q !== 36'h0) $display("FAIL mid_a50: got %h expected 0", bus.q); else passes++;
        bus.rdaddress = 6'd63;
        tick();
        checks++; if (bus.q !== 36'h0) $display("FAIL mid_a63: got %h expected 0", bus.q); else passes++;
    endtask

    task automatic test_reparam();
        int cnt;
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        cnt = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!bus2.busy) break;
            cnt++;
        end
        checks++; if (cnt !== 256) $display("FAIL rp_busy_len: got %0d expected 256", cnt); else passes++;
        bus2.wraddress = 8'd255;
        bus2.data = 32'hDEADBEEF;
        bus2.wren = 1'b1;
        tick();
        bus2.wren = 1'b0;
        bus2.rdaddress = 8'd255;
        tick();
        checks++; if (bus2.q !== 32'hDEADBEEF) $display("FAIL rp_a255: got %h expected deadbeef", bus2.q); else passes++;
        bus2.rdaddress = 8'd0;
        tick();
        checks++; if (bus2.q !== 32'h0) $display("FAIL rp_a0: got %h expected 0", bus2.q); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        reset2 = 1'b0;
        bus.data = '0;
        bus.wraddress = '0;
        bus.wren = 1'b0;
        bus.rdaddress = '0;
        bus2.data = '0;
        bus2.wraddress = '0;
        bus2.wren = 1'b0;
        bus2.rdaddress = '0;
        test_reset();
        test_latency();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid_clear();
        test_reparam();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
